// File: rtl/gvt_reducer.sv
// gvt_reducer: periodic global-virtual-time reduction across tiles.
// Once per 2^LOG_GVT_PERIOD enabled cycles, the block reads each tile's LVT (ts, tb)
// live, one tile per cycle. It takes the minimum over the valid tiles and publishes
// that minimum as the new GVT. GVT never moves backwards; a smaller result sets a
// sticky error flag instead. The block also detects termination (consecutive all-idle rounds).
// Ports:
//   clk, rstn      clock, async active-low reset
//   gvt_en         enables the period counter and the reduction; low aborts a round
//   lvt_ts/lvt_tb  per-tile LVT, tile i at [i*W +: W]
//   lvt_valid      per-tile busy flag; idle tiles are excluded from the minimum
//   gvt_ts/gvt_tb  current GVT (gvt_tb held 0 when USE_TB=0)
//   gvt_valid      one-cycle pulse when a round publishes
//   gvt_inf        last published round saw no valid tile
//   monotonic_err  sticky: a round produced a value below the current GVT
//   done           DONE_ROUNDS consecutive all-idle rounds observed
module gvt_reducer #(
  parameter int unsigned N_TILES        = 14,
  parameter int unsigned TS_WIDTH       = 32,
  parameter int unsigned TB_WIDTH       = 32,
  parameter int unsigned LOG_GVT_PERIOD = 5,
  parameter int unsigned USE_TB         = 1,
  parameter int unsigned DONE_ROUNDS    = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        gvt_en,
  input  logic [N_TILES*TS_WIDTH-1:0] lvt_ts,
  input  logic [N_TILES*TB_WIDTH-1:0] lvt_tb,
  input  logic [N_TILES-1:0]          lvt_valid,
  output logic [TS_WIDTH-1:0]         gvt_ts,
  output logic [TB_WIDTH-1:0]         gvt_tb,
  output logic                        gvt_valid,
  output logic                        gvt_inf,
  output logic                        monotonic_err,
  output logic                        done
);

  localparam int unsigned IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int unsigned CNT_W = LOG_GVT_PERIOD;
  localparam int unsigned IDL_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);
  localparam logic [IDL_W-1:0] DONE_TH  = IDL_W'(DONE_ROUNDS);

  // Parameter sanity: a round must finish before the counter comes round again.
  if ((N_TILES == 0) || (N_TILES > 64)) begin : g_chk_tiles
    $error("gvt_reducer: N_TILES must be in 1..64");
  end
  if ((N_TILES + 2) > (32'd1 << LOG_GVT_PERIOD)) begin : g_chk_period
    $error("gvt_reducer: N_TILES+2 must not exceed 2^LOG_GVT_PERIOD");
  end
  if ((DONE_ROUNDS == 0) || (DONE_ROUNDS > 15)) begin : g_chk_done
    $error("gvt_reducer: DONE_ROUNDS must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [TS_WIDTH-1:0] r_acc_ts;
  logic [TB_WIDTH-1:0] r_acc_tb;
  logic                r_any;
  logic [IDL_W-1:0]    r_idle_cnt;

  logic [TS_WIDTH-1:0] w_cur_ts;
  logic [TB_WIDTH-1:0] w_cur_tb;
  logic                w_cur_vld;
  logic                w_lt;
  logic                w_ge;
  logic [IDL_W-1:0]    w_idle_inc;

  // Live select of the tile addressed by the scan index.
  always_comb begin
    w_cur_ts  = '0;
    w_cur_tb  = '0;
    w_cur_vld = 1'b0;
    for (int unsigned i = 0; i < N_TILES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_ts  = lvt_ts[i*TS_WIDTH +: TS_WIDTH];
        w_cur_tb  = lvt_tb[i*TB_WIDTH +: TB_WIDTH];
        w_cur_vld = lvt_valid[i];
      end
    end
  end

  // Ordering: lexicographic (ts, tb), or ts alone when the tiebreaker is unused.
  if (USE_TB != 0) begin : g_tb
    assign w_lt = {w_cur_ts, w_cur_tb} < {r_acc_ts, r_acc_tb};
    assign w_ge = {r_acc_ts, r_acc_tb} >= {gvt_ts, gvt_tb};
  end else begin : g_no_tb
    logic w_unused_tb;
    assign w_unused_tb = ^{w_cur_tb, r_acc_tb};
    assign w_lt = w_cur_ts < r_acc_ts;
    assign w_ge = r_acc_ts >= gvt_ts;
  end

  // Saturating idle-round count.
  assign w_idle_inc = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + IDL_W'(1);

  // Period counter, scan FSM and published results.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_acc_ts      <= '1;
      r_acc_tb      <= '1;
      r_any         <= 1'b0;
      r_idle_cnt    <= '0;
      gvt_ts        <= '0;
      gvt_tb        <= '0;
      gvt_valid     <= 1'b0;
      gvt_inf       <= 1'b0;
      monotonic_err <= 1'b0;
      done          <= 1'b0;
    end else begin
      gvt_valid <= 1'b0;

      if (gvt_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        // Disabling breaks any run of idle rounds.
        done       <= 1'b0;
        r_idle_cnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (gvt_en && (r_cnt == '1)) begin
            r_acc_ts <= '1;
            r_acc_tb <= '1;
            r_any    <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (!gvt_en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            if (w_cur_vld && w_lt) begin
              r_acc_ts <= w_cur_ts;
              r_acc_tb <= w_cur_tb;
            end
            r_any <= r_any | w_cur_vld;
            if (r_idx == LAST_IDX) begin
              r_state <= S_PUBLISH;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        S_PUBLISH: begin
          r_state <= S_IDLE;
          if (!gvt_en) begin
            r_cnt <= '0;
          end else begin
            gvt_valid <= 1'b1;
            if (r_any) begin
              gvt_inf    <= 1'b0;
              r_idle_cnt <= '0;
              done       <= 1'b0;
              if (w_ge) begin
                gvt_ts <= r_acc_ts;
                gvt_tb <= (USE_TB != 0) ? r_acc_tb : '0;
              end else begin
                monotonic_err <= 1'b1;
              end
            end else begin
              gvt_inf    <= 1'b1;
              r_idle_cnt <= w_idle_inc;
              if (w_idle_inc >= DONE_TH) begin
                done <= 1'b1;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gvt_reducer.sv
// Bench for gvt_reducer: two instances (with and without tiebreak) share stimulus.
// A snapshot-based reference model recomputes each round's minimum from recorded inputs.
module tb_gvt_reducer;

  localparam int unsigned N      = 4;
  localparam int unsigned TSW    = 32;
  localparam int unsigned TBW    = 32;
  localparam int unsigned P      = 3;
  localparam int unsigned PERIOD = 8;
  localparam int unsigned DR     = 2;
  localparam int unsigned NV     = 8;

  logic             clk;
  logic             rstn;
  logic             gvt_en;
  logic [N*TSW-1:0] lvt_ts;
  logic [N*TBW-1:0] lvt_tb;
  logic [N-1:0]     lvt_valid;

  logic [TSW-1:0] d_ts    [2];
  logic [TBW-1:0] d_tb    [2];
  logic           d_valid [2];
  logic           d_inf   [2];
  logic           d_err   [2];
  logic           d_done  [2];

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gvt_reducer #(
    .N_TILES(N), .TS_WIDTH(TSW), .TB_WIDTH(TBW), .LOG_GVT_PERIOD(P),
    .USE_TB(1), .DONE_ROUNDS(DR)
  ) u_dut_tb (
    .clk(clk), .rstn(rstn), .gvt_en(gvt_en),
    .lvt_ts(lvt_ts), .lvt_tb(lvt_tb), .lvt_valid(lvt_valid),
    .gvt_ts(d_ts[0]), .gvt_tb(d_tb[0]), .gvt_valid(d_valid[0]),
    .gvt_inf(d_inf[0]), .monotonic_err(d_err[0]), .done(d_done[0])
  );

  gvt_reducer #(
    .N_TILES(N), .TS_WIDTH(TSW), .TB_WIDTH(TBW), .LOG_GVT_PERIOD(P),
    .USE_TB(0), .DONE_ROUNDS(DR)
  ) u_dut_ts (
    .clk(clk), .rstn(rstn), .gvt_en(gvt_en),
    .lvt_ts(lvt_ts), .lvt_tb(lvt_tb), .lvt_valid(lvt_valid),
    .gvt_ts(d_ts[1]), .gvt_tb(d_tb[1]), .gvt_valid(d_valid[1]),
    .gvt_inf(d_inf[1]), .monotonic_err(d_err[1]), .done(d_done[1])
  );

  // ---------------- reference model (index 0: tiebreak used, 1: ts only) ----------------
  int          m_cyc;
  int          m_cnt    [2];
  bit          m_active [2];
  int          m_T      [2];
  bit [31:0]   m_gvt_ts [2];
  bit [31:0]   m_gvt_tb [2];
  bit          m_valid  [2];
  bit          m_inf    [2];
  bit          m_err    [2];
  bit          m_done   [2];
  int          m_idle   [2];
  bit [31:0]   h_ts [16][N];
  bit [31:0]   h_tb [16][N];
  bit          h_v  [16][N];

  task automatic model_reset();
    m_cyc = 0;
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0; m_active[u] = 0; m_T[u] = 0;
      m_gvt_ts[u] = 0; m_gvt_tb[u] = 0; m_valid[u] = 0;
      m_inf[u] = 0; m_err[u] = 0; m_done[u] = 0; m_idle[u] = 0;
    end
  endtask

  // Minimum over the tiles as each was seen on its own read cycle, then publish rules.
  task automatic model_publish(input int u);
    bit        any;
    bit [63:0] best;
    bit [63:0] key;
    bit [63:0] cur;
    int        c;
    any  = 0;
    best = '1;
    for (int i = 0; i < N; i++) begin
      c = (m_T[u] + 1 + i) % 16;
      if (h_v[c][i]) begin
        key = (u == 0) ? {h_ts[c][i], h_tb[c][i]} : {h_ts[c][i], 32'd0};
        if (!any || key < best) best = key;
        any = 1;
      end
    end
    m_valid[u]  = 1;
    m_active[u] = 0;
    if (any) begin
      m_inf[u] = 0; m_idle[u] = 0; m_done[u] = 0;
      cur = {m_gvt_ts[u], m_gvt_tb[u]};
      if (best >= cur) begin
        m_gvt_ts[u] = best[63:32];
        m_gvt_tb[u] = best[31:0];
      end else begin
        m_err[u] = 1;
      end
    end else begin
      m_inf[u] = 1;
      if (m_idle[u] < 15) m_idle[u]++;
      if (m_idle[u] >= int'(DR)) m_done[u] = 1;
    end
  endtask

  // Advance one clock using the inputs that were stable at the edge just taken.
  task automatic model_step();
    int slot;
    if (!rstn) begin
      model_reset();
      return;
    end
    slot = m_cyc % 16;
    for (int i = 0; i < N; i++) begin
      h_ts[slot][i] = lvt_ts[i*TSW +: TSW];
      h_tb[slot][i] = lvt_tb[i*TBW +: TBW];
      h_v[slot][i]  = lvt_valid[i];
    end
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0;
      if (!gvt_en) begin
        if (m_active[u]) begin
          m_active[u] = 0;
          m_cnt[u]    = 0;
        end
        m_done[u] = 0;
        m_idle[u] = 0;
      end else begin
        if (m_active[u] && m_cyc == m_T[u] + int'(N) + 1) model_publish(u);
        if (!m_active[u] && m_cnt[u] == int'(PERIOD) - 1) begin
          m_active[u] = 1;
          m_T[u]      = m_cyc;
        end
        m_cnt[u] = (m_cnt[u] + 1) % int'(PERIOD);
      end
    end
    m_cyc++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("model_gvt_ts_u%0d", u), 64'(d_ts[u]), 64'(m_gvt_ts[u]));
      chk($sformatf("model_gvt_tb_u%0d", u), 64'(d_tb[u]), 64'(m_gvt_tb[u]));
      chk($sformatf("model_gvt_valid_u%0d", u), 64'(d_valid[u]), 64'(m_valid[u]));
      chk($sformatf("model_gvt_inf_u%0d", u), 64'(d_inf[u]), 64'(m_inf[u]));
      chk($sformatf("model_mono_err_u%0d", u), 64'(d_err[u]), 64'(m_err[u]));
      chk($sformatf("model_done_u%0d", u), 64'(d_done[u]), 64'(m_done[u]));
    end
  endtask

  task automatic wait_pulse(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (d_valid[0]) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_pulse_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic chk_zero(input string nm);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_ts_u%0d", nm, u), 64'(d_ts[u]), 64'd0);
      chk($sformatf("%s_tb_u%0d", nm, u), 64'(d_tb[u]), 64'd0);
      chk($sformatf("%s_valid_u%0d", nm, u), 64'(d_valid[u]), 64'd0);
      chk($sformatf("%s_inf_u%0d", nm, u), 64'(d_inf[u]), 64'd0);
      chk($sformatf("%s_err_u%0d", nm, u), 64'(d_err[u]), 64'd0);
      chk($sformatf("%s_done_u%0d", nm, u), 64'(d_done[u]), 64'd0);
    end
  endtask

  // ---------------- directed vectors: one record per reduction round ----------------
  typedef struct {
    logic [N*TSW-1:0] ts;
    logic [N*TBW-1:0] tb;
    logic [N-1:0]     v;
    logic [31:0]      e_ts;
    logic [31:0]      e_tb;
    logic [31:0]      e_ts0;
    logic             e_inf;
    logic             e_err;
    logic             e_done;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mk(input logic [N*TSW-1:0] ts, input logic [N*TBW-1:0] tb,
                              input logic [N-1:0] v, input logic [31:0] e_ts,
                              input logic [31:0] e_tb, input logic [31:0] e_ts0,
                              input logic e_inf, input logic e_err, input logic e_done);
    vec_t r;
    r.ts = ts; r.tb = tb; r.v = v;
    r.e_ts = e_ts; r.e_tb = e_tb; r.e_ts0 = e_ts0;
    r.e_inf = e_inf; r.e_err = e_err; r.e_done = e_done;
    return r;
  endfunction

  task automatic apply(input int r);
    lvt_ts    = vec[r].ts;
    lvt_tb    = vec[r].tb;
    lvt_valid = vec[r].v;
  endtask

  task automatic chk_rec(input int r);
    string p;
    p = $sformatf("vec%0d", r);
    chk({p, "_gvt_ts"},  64'(d_ts[0]), 64'(vec[r].e_ts));
    chk({p, "_gvt_tb"},  64'(d_tb[0]), 64'(vec[r].e_tb));
    chk({p, "_ts_only_gvt_ts"}, 64'(d_ts[1]), 64'(vec[r].e_ts0));
    chk({p, "_ts_only_gvt_tb"}, 64'(d_tb[1]), 64'd0);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_inf_u%0d", p, u),  64'(d_inf[u]),  64'(vec[r].e_inf));
      chk($sformatf("%s_err_u%0d", p, u),  64'(d_err[u]),  64'(vec[r].e_err));
      chk($sformatf("%s_done_u%0d", p, u), 64'(d_done[u]), 64'(vec[r].e_done));
    end
  endtask

  initial begin
    int np;
    int first;
    int base;
    int en_low;
    bit idle_mode;

    n_checks = 0;
    n_fail   = 0;
    rstn      = 1'b0;
    gvt_en    = 1'b0;
    lvt_ts    = '0;
    lvt_tb    = '0;
    lvt_valid = '0;
    model_reset();

    // tile 0 in the low slice
    vec[0] = mk({32'd12, 32'd33, 32'd12, 32'd40}, {32'd5, 32'd0, 32'd9, 32'd0}, 4'hF,
                32'd12, 32'd5, 32'd12, 1'b0, 1'b0, 1'b0);
    vec[1] = mk({4{32'd20}}, '0, 4'hF, 32'd20, 32'd0, 32'd20, 1'b0, 1'b0, 1'b0);
    vec[2] = mk({4{32'd15}}, '0, 4'hF, 32'd20, 32'd0, 32'd20, 1'b0, 1'b1, 1'b0);
    vec[3] = mk({4{32'd25}}, '0, 4'hF, 32'd25, 32'd0, 32'd25, 1'b0, 1'b1, 1'b0);
    vec[4] = mk({4{32'd5}},  '0, 4'h0, 32'd25, 32'd0, 32'd25, 1'b1, 1'b1, 1'b0);
    vec[5] = mk({4{32'd5}},  '0, 4'h0, 32'd25, 32'd0, 32'd25, 1'b1, 1'b1, 1'b1);
    vec[6] = mk({32'd1, 32'd1, 32'd1, 32'd50}, '0, 4'h1,
                32'd50, 32'd0, 32'd50, 1'b0, 1'b1, 1'b0);
    vec[7] = mk({4{32'd60}}, {32'd4, 32'd9, 32'd3, 32'd7}, 4'hF,
                32'd60, 32'd3, 32'd60, 1'b0, 1'b1, 1'b0);

    // reset state
    tick();
    tick();
    chk_zero("reset");

    // directed rounds
    #1;
    rstn   = 1'b1;
    gvt_en = 1'b1;
    apply(0);
    for (int r = 0; r < int'(NV); r++) begin
      wait_pulse($sformatf("vec%0d", r));
      chk_rec(r);
      if (r + 1 < int'(NV)) begin
        #1;
        apply(r + 1);
      end
    end

    // abort: drop enable while the scan is on tile 2
    repeat (5) tick();
    #1;
    gvt_en = 1'b0;
    np = 0;
    repeat (12) begin
      tick();
      if (d_valid[0] || d_valid[1]) np++;
    end
    chk("abort_no_pulse", 64'(np), 64'd0);
    chk("abort_hold_ts", 64'(d_ts[0]), 64'd60);
    chk("abort_hold_tb", 64'(d_tb[0]), 64'd3);
    #1;
    gvt_en = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (d_valid[0] && first == 0) first = k;
    end
    chk("reenable_latency", 64'(first), 64'd13);

    // live read: tile 3 changes after the scan has started
    #1;
    rstn      = 1'b0;
    lvt_valid = '0;
    tick();
    #1;
    rstn = 1'b1;
    wait_pulse("live_pre");
    chk("live_pre_inf", 64'(d_inf[0]), 64'd1);
    #1;
    lvt_ts    = {32'd7, 32'd30, 32'd30, 32'd30};
    lvt_tb    = '0;
    lvt_valid = 4'hF;
    repeat (4) tick();
    #1;
    lvt_ts[3*TSW +: TSW] = 32'd3;
    wait_pulse("live");
    chk("live_read_ts_u0", 64'(d_ts[0]), 64'd3);
    chk("live_read_ts_u1", 64'(d_ts[1]), 64'd3);

    // async reset in the middle of a scan
    repeat (4) tick();
    #1;
    rstn = 1'b0;
    #1;
    chk_zero("midscan_reset");
    tick();
    #1;
    rstn = 1'b1;

    // randomized traffic against the model
    base      = 100;
    en_low    = 0;
    idle_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      #1;
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 499) == 0) rstn = 1'b0;
      if (en_low > 0) begin
        en_low--;
        if (en_low == 0) gvt_en = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        gvt_en = 1'b0;
        en_low = int'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 149) == 0) idle_mode = ~idle_mode;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 39) == 0 && base > 30) base -= 25;
        else base += int'($urandom_range(0, 3));
        for (int i = 0; i < int'(N); i++) begin
          if ($urandom_range(0, 29) == 0) lvt_ts[i*TSW +: TSW] = 32'hFFFF_FFFF;
          else lvt_ts[i*TSW +: TSW] = 32'(base + int'($urandom_range(0, 7)));
          lvt_tb[i*TBW +: TBW] = 32'($urandom_range(0, 3));
        end
        lvt_valid = idle_mode ? 4'h0 : 4'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
